// File: rtl/idma_rd_pkg.sv
// rtl/idma_rd_pkg.sv - shared types and constants for the iDMA read burst scheduler
package idma_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } rd_state_e;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam int unsigned BOUNDARY_4K    = 4096;

  function automatic logic [2:0] axi_size_log2(input int unsigned bpb);
    logic [2:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      if ((32'd1 << i) == bpb) s = 3'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/idma_burst_len_calc.sv
// rtl/idma_burst_len_calc.sv - beats in the next INCR burst: min of cap, remaining, room to 4 KB
module idma_burst_len_calc
  import idma_rd_pkg::*;
#(
  parameter int unsigned BPB       = 32,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned LEN_WID   = 16
) (
  input  logic [11:0]        addr_offs,
  input  logic [LEN_WID-1:0] rem_beats,
  output logic [8:0]         blen
);

  localparam int unsigned SIZE = 32'(axi_size_log2(BPB));

  logic [31:0] room;
  logic [31:0] lim;

  always_comb begin
    room = (BOUNDARY_4K - 32'(addr_offs)) >> SIZE;
    lim  = MAX_BURST;
    if (32'(rem_beats) < lim) lim = 32'(rem_beats);
    if (room < lim) lim = room;
    blen = 9'(lim);
  end

endmodule

// File: rtl/idma_rd_burst_ctrl.sv
// rtl/idma_rd_burst_ctrl.sv - splits one read descriptor into 4 KB-safe AR bursts with outstanding limit
module idma_rd_burst_ctrl
  import idma_rd_pkg::*;
#(
  parameter int unsigned AXI_IDW      = 4,
  parameter int unsigned AXI_ADDR_WID = 32,
  parameter int unsigned AXI_DATA_WID = 256,
  parameter int unsigned ID           = 0,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned MAX_OUTSTD   = 4,
  parameter int unsigned LEN_WID      = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    dma_start,
  input  logic [AXI_ADDR_WID-1:0] dma_base_addr,
  input  logic [LEN_WID-1:0]      dma_total_beats,
  output logic                    dma_busy,
  output logic                    dma_done,
  output logic                    o_arvalid,
  input  logic                    i_arready,
  output logic [AXI_ADDR_WID-1:0] o_araddr,
  output logic [7:0]              o_arlen,
  output logic [2:0]              o_arsize,
  output logic [1:0]              o_arburst,
  output logic [AXI_IDW-1:0]      o_arid,
  input  logic                    axi_burst_rdata_ok,
  output logic                    dma_trans_first_burst,
  output logic                    dma_trans_last_burst
);

  localparam int unsigned BPB    = AXI_DATA_WID / 8;
  localparam logic [2:0]  SIZE   = axi_size_log2(BPB);
  localparam int unsigned OCW    = $clog2(MAX_OUTSTD + 1);
  localparam logic [31:0] ID_VEC = 32'(ID);

  rd_state_e               state, state_d;
  logic [AXI_ADDR_WID-1:0] cur_addr, cur_addr_d;
  logic [LEN_WID-1:0]      rem_beats, rem_d;
  logic [OCW-1:0]          out_cnt, out_d;
  logic                    cpl_seen, cpl_d;
  logic [8:0]              blen_q, blen_nxt;
  logic                    hs, cpl;

  assign o_araddr  = cur_addr;
  assign o_arsize  = SIZE;
  assign o_arburst = AXI_BURST_INCR;
  assign o_arid    = ID_VEC[AXI_IDW-1:0];

  // Length is evaluated on the next address/remainder so it is already registered when arvalid rises
  idma_burst_len_calc #(
    .BPB       (BPB),
    .MAX_BURST (MAX_BURST),
    .LEN_WID   (LEN_WID)
  ) u_len_calc (
    .addr_offs (cur_addr_d[11:0]),
    .rem_beats (rem_d),
    .blen      (blen_nxt)
  );

  always_comb begin
    state_d    = state;
    cur_addr_d = cur_addr;
    rem_d      = rem_beats;
    out_d      = out_cnt;
    cpl_d      = cpl_seen;
    hs         = o_arvalid & i_arready;
    cpl        = axi_burst_rdata_ok & (out_cnt != '0);

    if (hs)  out_d = out_d + OCW'(1);
    if (cpl) out_d = out_d - OCW'(1);
    if (cpl) cpl_d = 1'b1;

    case (state)
      ST_IDLE: begin
        if (dma_start) begin
          cur_addr_d = dma_base_addr;
          rem_d      = dma_total_beats;
          out_d      = '0;
          cpl_d      = 1'b0;
          state_d    = (dma_total_beats == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (hs) begin
          cur_addr_d = cur_addr + (AXI_ADDR_WID'(blen_q) << SIZE);
          rem_d      = rem_beats - LEN_WID'(blen_q);
          if (rem_beats == LEN_WID'(blen_q)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_d == '0) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state                 <= ST_IDLE;
      cur_addr              <= '0;
      rem_beats             <= '0;
      out_cnt               <= '0;
      cpl_seen              <= 1'b0;
      blen_q                <= '0;
      o_arlen               <= '0;
      o_arvalid             <= 1'b0;
      dma_busy              <= 1'b0;
      dma_done              <= 1'b0;
      dma_trans_first_burst <= 1'b0;
      dma_trans_last_burst  <= 1'b0;
    end else begin
      state                 <= state_d;
      cur_addr              <= cur_addr_d;
      rem_beats             <= rem_d;
      out_cnt               <= out_d;
      cpl_seen              <= cpl_d;
      blen_q                <= blen_nxt;
      o_arlen               <= (blen_nxt == '0) ? 8'd0 : 8'(blen_nxt - 9'd1);
      o_arvalid             <= (state_d == ST_ISSUE) && (out_d < OCW'(MAX_OUTSTD));
      dma_busy              <= (state_d != ST_IDLE);
      dma_done              <= (state == ST_DONE);
      dma_trans_first_burst <= (state_d != ST_IDLE) && !cpl_d;
      dma_trans_last_burst  <= (state_d != ST_IDLE) && (rem_d == '0) && (out_d == OCW'(1));
    end
  end

endmodule

// File: tb/tb_idma_rd_burst_ctrl.sv
// tb/tb_idma_rd_burst_ctrl.sv - self-checking bench for idma_rd_burst_ctrl
module tb_idma_rd_burst_ctrl;

  localparam int BPB  = 32;
  localparam int MAXB = 16;
  localparam int MAXO = 4;

  logic        aclk;
  logic        aresetn;
  logic        dma_start;
  logic [31:0] dma_base_addr;
  logic [15:0] dma_total_beats;
  logic        dma_busy;
  logic        dma_done;
  logic        o_arvalid;
  logic        i_arready;
  logic [31:0] o_araddr;
  logic [7:0]  o_arlen;
  logic [2:0]  o_arsize;
  logic [1:0]  o_arburst;
  logic [3:0]  o_arid;
  logic        axi_burst_rdata_ok;
  logic        dma_trans_first_burst;
  logic        dma_trans_last_burst;

  int n_checks = 0;
  int n_fail   = 0;

  idma_rd_burst_ctrl dut (
    .aclk                  (aclk),
    .aresetn               (aresetn),
    .dma_start             (dma_start),
    .dma_base_addr         (dma_base_addr),
    .dma_total_beats       (dma_total_beats),
    .dma_busy              (dma_busy),
    .dma_done              (dma_done),
    .o_arvalid             (o_arvalid),
    .i_arready             (i_arready),
    .o_araddr              (o_araddr),
    .o_arlen               (o_arlen),
    .o_arsize              (o_arsize),
    .o_arburst             (o_arburst),
    .o_arid                (o_arid),
    .axi_burst_rdata_ok    (axi_burst_rdata_ok),
    .dma_trans_first_burst (dma_trans_first_burst),
    .dma_trans_last_burst  (dma_trans_last_burst)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] base;
    int          beats;
    int          rdy_pct;
    int          cpl_pct;
    int          hold;
    int          rdy_low_at;
    int          restart_at;
    int          exp_nb;
    logic [7:0]  exp_first_len;
    logic [31:0] exp_last_addr;
    logic [7:0]  exp_last_len;
  } vec_t;

  // Runs one descriptor; the expected burst list comes from the 4 KB / cap / remainder rule
  task automatic run_xfer(input logic [31:0] base, input int beats, input int rdy_pct,
                          input int cpl_pct, input int hold, input int rdy_low_at,
                          input int restart_at, output int n_hs, output logic [7:0] f_len,
                          output logic [31:0] l_addr, output logic [7:0] l_len,
                          output int n_done);
    logic [31:0] ea[$];
    logic [7:0]  el[$];
    int unsigned a;
    int r, b, room, nb, issued, outst, cpl_n, fin;
    bit finished, hs, cpl, e_busy;
    a = base; r = beats;
    while (r > 0) begin
      room = (4096 - int'(a % 4096)) / BPB;
      b = MAXB;
      if (r < b) b = r;
      if (room < b) b = room;
      ea.push_back(a);
      el.push_back(8'(b - 1));
      a = a + b * BPB;
      r = r - b;
    end
    nb = ea.size();
    n_hs = 0; f_len = '0; l_addr = '0; l_len = '0; n_done = 0;
    issued = 0; outst = 0; cpl_n = 0; fin = -1; finished = 0;

    @(negedge aclk);
    chk("idle_arvalid", 64'(o_arvalid), 64'(0));
    chk("idle_busy", 64'(dma_busy), 64'(0));
    dma_start = 1'b1; dma_base_addr = base; dma_total_beats = 16'(beats);
    i_arready = 1'b0; axi_burst_rdata_ok = 1'b0;

    for (int k = 1; k <= 2000; k++) begin
      @(negedge aclk);
      dma_start = (k == restart_at);
      if (k == restart_at) begin
        dma_base_addr = 32'hDEAD_0000; dma_total_beats = 16'd7;
      end
      if (k == 1) begin
        chk("arsize", 64'(o_arsize), 64'(5));
        chk("arburst", 64'(o_arburst), 64'(1));
        chk("arid", 64'(o_arid), 64'(0));
      end
      if (fin < 0 && issued == nb && outst == 0) fin = k;
      e_busy = (fin < 0) || (k <= fin);
      chk("busy", 64'(dma_busy), 64'(e_busy));
      chk("done", 64'(dma_done), 64'(fin >= 0 && k == fin + 1));
      chk("arvalid", 64'(o_arvalid), 64'(issued < nb && outst < MAXO));
      chk("first_flag", 64'(dma_trans_first_burst), 64'(e_busy && cpl_n == 0));
      chk("last_flag", 64'(dma_trans_last_burst), 64'(e_busy && issued == nb && outst == 1));
      if (o_arvalid && issued < nb) begin
        chk("araddr", 64'(o_araddr), 64'(ea[issued]));
        chk("arlen", 64'(o_arlen), 64'(el[issued]));
      end
      if (hold > 0 && k == hold) chk("outstd_cap", 64'(issued), 64'(MAXO));
      if (dma_done) n_done++;
      if (fin >= 0 && k == fin + 1) begin
        finished = 1;
        i_arready = 1'b0; axi_burst_rdata_ok = 1'b0;
        break;
      end
      if (rdy_low_at > 0 && k >= rdy_low_at && k < rdy_low_at + 5) i_arready = 1'b0;
      else i_arready = ($urandom_range(0, 99) < rdy_pct);
      hs  = o_arvalid && i_arready;
      cpl = (outst > 0) && (k > hold) && ($urandom_range(0, 99) < cpl_pct);
      axi_burst_rdata_ok = cpl;
      if (hs) begin
        if (issued == 0) f_len = o_arlen;
        l_addr = o_araddr; l_len = o_arlen;
        issued++; outst++; n_hs++;
      end
      if (cpl) begin
        outst--; cpl_n++;
      end
    end
    if (!finished) chk("xfer_timeout", 64'(0), 64'(1));
    @(negedge aclk);
    chk("done_width", 64'(dma_done), 64'(0));
  endtask

  vec_t        vecs[7];
  int          n_hs, n_done;
  logic [7:0]  f_len, l_len;
  logic [31:0] l_addr;

  initial begin
    vecs[0] = '{32'h0000_0000, 40, 100, 100, 0, 0, 0, 3, 8'd15, 32'h0000_0400, 8'd7};
    vecs[1] = '{32'h0000_0FC0, 4, 100, 100, 0, 0, 0, 2, 8'd1, 32'h0000_1000, 8'd1};
    vecs[2] = '{32'h0000_0000, 100, 100, 100, 12, 0, 0, 7, 8'd15, 32'h0000_0C00, 8'd3};
    vecs[3] = '{32'h0000_0F00, 20, 100, 60, 0, 2, 0, 2, 8'd7, 32'h0000_1000, 8'd11};
    vecs[4] = '{32'h0000_0000, 0, 100, 100, 0, 0, 0, 0, 8'd0, 32'h0000_0000, 8'd0};
    vecs[5] = '{32'h0000_1FE0, 33, 50, 30, 0, 0, 3, 3, 8'd0, 32'h0000_2200, 8'd15};
    vecs[6] = '{32'h0000_3000, 1, 100, 100, 0, 0, 0, 1, 8'd0, 32'h0000_3000, 8'd0};

    aresetn = 1'b0; dma_start = 1'b0; dma_base_addr = '0; dma_total_beats = '0;
    i_arready = 1'b0; axi_burst_rdata_ok = 1'b0;
    repeat (3) @(negedge aclk);
    chk("rst_arvalid", 64'(o_arvalid), 64'(0));
    chk("rst_busy", 64'(dma_busy), 64'(0));
    chk("rst_done", 64'(dma_done), 64'(0));
    chk("rst_araddr", 64'(o_araddr), 64'(0));
    chk("rst_arlen", 64'(o_arlen), 64'(0));
    chk("rst_first", 64'(dma_trans_first_burst), 64'(0));
    chk("rst_last", 64'(dma_trans_last_burst), 64'(0));
    aresetn = 1'b1;

    foreach (vecs[i]) begin
      run_xfer(vecs[i].base, vecs[i].beats, vecs[i].rdy_pct, vecs[i].cpl_pct, vecs[i].hold,
               vecs[i].rdy_low_at, vecs[i].restart_at, n_hs, f_len, l_addr, l_len, n_done);
      chk($sformatf("vec%0d_nbursts", i), 64'(n_hs), 64'(vecs[i].exp_nb));
      chk($sformatf("vec%0d_first_len", i), 64'(f_len), 64'(vecs[i].exp_first_len));
      chk($sformatf("vec%0d_last_addr", i), 64'(l_addr), 64'(vecs[i].exp_last_addr));
      chk($sformatf("vec%0d_last_len", i), 64'(l_len), 64'(vecs[i].exp_last_len));
      chk($sformatf("vec%0d_done_cnt", i), 64'(n_done), 64'(1));
    end

    // Abort a transfer mid-issue with an asynchronous reset
    @(negedge aclk);
    dma_start = 1'b1; dma_base_addr = 32'h0; dma_total_beats = 16'd100; i_arready = 1'b1;
    @(negedge aclk);
    dma_start = 1'b0;
    repeat (2) @(negedge aclk);
    chk("pre_rst_arvalid", 64'(o_arvalid), 64'(1));
    chk("pre_rst_busy", 64'(dma_busy), 64'(1));
    #2 aresetn = 1'b0;
    #1;
    chk("async_rst_arvalid", 64'(o_arvalid), 64'(0));
    chk("async_rst_busy", 64'(dma_busy), 64'(0));
    chk("async_rst_araddr", 64'(o_araddr), 64'(0));
    chk("async_rst_arlen", 64'(o_arlen), 64'(0));
    chk("async_rst_first", 64'(dma_trans_first_burst), 64'(0));
    @(negedge aclk);
    aresetn = 1'b1; i_arready = 1'b0;
    run_xfer(vecs[0].base, vecs[0].beats, 100, 100, 0, 0, 0, n_hs, f_len, l_addr, l_len, n_done);
    chk("post_rst_nbursts", 64'(n_hs), 64'(3));
    chk("post_rst_last_addr", 64'(l_addr), 64'(32'h400));
    chk("post_rst_done_cnt", 64'(n_done), 64'(1));

    // Randomised descriptors against the burst-splitting model
    for (int t = 0; t < 15; t++) begin
      logic [31:0] rb;
      int rbeats, mnb, r, b, room;
      int unsigned a;
      rb = {18'd0, 9'($urandom_range(0, 511)), 5'd0};
      rbeats = $urandom_range(0, 60);
      a = rb; r = rbeats; mnb = 0;
      while (r > 0) begin
        room = (4096 - int'(a % 4096)) / BPB;
        b = (r < MAXB) ? r : MAXB;
        if (room < b) b = room;
        a = a + b * BPB; r = r - b; mnb++;
      end
      run_xfer(rb, rbeats, $urandom_range(30, 100), $urandom_range(20, 100), 0, 0, 0,
               n_hs, f_len, l_addr, l_len, n_done);
      chk($sformatf("rand%0d_nbursts", t), 64'(n_hs), 64'(mnb));
      chk($sformatf("rand%0d_done_cnt", t), 64'(n_done), 64'(1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
